// File: rtl/adrv9001_clk_en_gen.sv
// Per-channel divided clock-enable generator with a common sync that realigns every channel.
// Define ADRV9001_CLK_EN_GEN_DIV_CLK_EN to build the divided-clock (div_clk) level logic.
module adrv9001_clk_en_gen #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        sync,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div,
    output logic [NUM_CH-1:0]           ce,
    output logic [NUM_CH-1:0]           div_clk,
    output logic                        aligned
);

    logic                 rst_meta_q;
    logic                 run_q;
    logic [DIV_WIDTH-1:0] cnt_q   [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_d   [NUM_CH];
    logic [DIV_WIDTH-1:0] ract_q  [NUM_CH];
    logic [DIV_WIDTH-1:0] ract_d  [NUM_CH];
    logic [DIV_WIDTH-1:0] div_eff [NUM_CH];
    logic [NUM_CH-1:0]    ce_q;
    logic [NUM_CH-1:0]    ce_d;
    logic [NUM_CH-1:0]    en_prev_q;
    logic                 aligned_q;
    logic                 aligned_d;
    logic                 phase_lost;

    // Until the release synchroniser reports run, channels behave as disabled so ract tracks div.
    always_comb begin
        phase_lost = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_eff[i] = (div[i*DIV_WIDTH +: DIV_WIDTH] == '0) ? DIV_WIDTH'(1)
                                                               : div[i*DIV_WIDTH +: DIV_WIDTH];
            cnt_d[i]   = cnt_q[i];
            ract_d[i]  = ract_q[i];
            ce_d[i]    = 1'b0;
            if (sync || !ch_en[i] || !run_q) begin
                cnt_d[i]  = '0;
                ract_d[i] = div_eff[i];
            end else if (cnt_q[i] >= ract_q[i] - 1'b1) begin
                cnt_d[i]  = '0;
                ce_d[i]   = 1'b1;
                ract_d[i] = div_eff[i];
                if (div_eff[i] != ract_q[i]) phase_lost = 1'b1;
            end else begin
                cnt_d[i]  = cnt_q[i] + 1'b1;
            end
            if (ch_en[i] && !en_prev_q[i]) phase_lost = 1'b1;
        end
        aligned_d = sync ? 1'b1 : (phase_lost ? 1'b0 : aligned_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_meta_q <= 1'b0;
            run_q      <= 1'b0;
            ce_q       <= '0;
            en_prev_q  <= '0;
            aligned_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                ract_q[i] <= DIV_WIDTH'(1);
            end
        end else begin
            rst_meta_q <= 1'b1;
            run_q      <= rst_meta_q;
            ce_q       <= ce_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                ract_q[i] <= ract_d[i];
            end
            if (run_q) begin
                en_prev_q <= ch_en;
                aligned_q <= aligned_d;
            end
        end
    end

    assign ce      = ce_q;
    assign aligned = aligned_q;

`ifdef ADRV9001_CLK_EN_GEN_DIV_CLK_EN
    logic [NUM_CH-1:0] dc_q;
    logic [NUM_CH-1:0] dc_d;
    logic [DIV_WIDTH:0] half [NUM_CH];

    // High for the first ceil(ract/2) counts of each period; one extra bit avoids overflow at max ratio.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            half[i] = ({1'b0, ract_d[i]} + 1'b1) >> 1;
            dc_d[i] = run_q && ch_en[i] && !sync && ({1'b0, cnt_d[i]} < half[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dc_q <= '0;
        end else begin
            dc_q <= dc_d;
        end
    end

    assign div_clk = dc_q;
`else
    assign div_clk = '0;
`endif

endmodule

// File: tb/tb_adrv9001_clk_en_gen.sv
// Directed bench for adrv9001_clk_en_gen: a driver pushes hand-computed per-cycle expectations,
// a monitor pops and compares them one clock edge later.
module tb_adrv9001_clk_en_gen;

  localparam int NUM_CH = 2;
  localparam int DW     = 8;
  localparam int W      = 2 * NUM_CH + 1;

`ifdef ADRV9001_CLK_EN_GEN_DIV_CLK_EN
  localparam bit DC_ON = 1'b1;
`else
  localparam bit DC_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  logic sync;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH*DW-1:0] div;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] div_clk;
  logic aligned;

  always #5 clk = ~clk;

  adrv9001_clk_en_gen #(.NUM_CH(NUM_CH), .DIV_WIDTH(DW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sync    (sync),
    .ch_en   (ch_en),
    .div     (div),
    .ce      (ce),
    .div_clk (div_clk),
    .aligned (aligned)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int step_idx = 0;
  int mon_idx = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d @%0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge and queue what it must produce.
  task automatic step(input logic s, input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] ece, input logic [1:0] edc, input logic eal);
    logic [1:0] dc_exp;
    dc_exp = DC_ON ? edc : 2'b00;
    sync  = s;
    ch_en = en;
    div   = {d1, d0};
    exp_q.push_back({ece, dc_exp, eal});
    step_idx++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mon_idx++;
      chk("ce", mon_idx, 8'(ce), 8'(e[4:3]));
      chk("div_clk", mon_idx, 8'(div_clk), 8'(e[2:1]));
      chk("aligned", mon_idx, 8'(aligned), 8'(e[0]));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rstn  = 1'b0;
    sync  = 1'b0;
    ch_en = '0;
    div   = '0;
    #2;
    chk("reset_ce", 0, 8'(ce), 8'h0);
    chk("reset_div_clk", 0, 8'(div_clk), 8'h0);
    chk("reset_aligned", 0, 8'(aligned), 8'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // A: two held edges after release, then div=4 counting
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b01, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b01, 2'b01, 0);

    // B: sync, div=4 ce every 4th cycle, then 4->6 at cnt=1
    step(1, 2'b01, 4, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b01, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 4, 5, 2'b01, 2'b01, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b01, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 4, 5, 2'b01, 2'b01, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b01, 1);
    step(0, 2'b01, 6, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 6, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 6, 5, 2'b01, 2'b01, 0);
    step(0, 2'b01, 6, 5, 2'b00, 2'b01, 0);
    step(0, 2'b01, 6, 5, 2'b00, 2'b01, 0);
    step(0, 2'b01, 6, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 6, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 6, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 6, 5, 2'b01, 2'b01, 0);

    // C: div=3 / div=5 free-running, sync with ch1 rising, then sync mid-period
    step(1, 2'b11, 3, 5, 2'b00, 2'b00, 1);
    step(0, 2'b11, 3, 5, 2'b00, 2'b11, 1);
    step(0, 2'b11, 3, 5, 2'b00, 2'b10, 1);
    step(0, 2'b11, 3, 5, 2'b01, 2'b01, 1);
    step(0, 2'b11, 3, 5, 2'b00, 2'b01, 1);
    step(0, 2'b11, 3, 5, 2'b10, 2'b10, 1);
    step(0, 2'b11, 3, 5, 2'b01, 2'b11, 1);
    step(1, 2'b11, 3, 5, 2'b00, 2'b00, 1);
    step(0, 2'b11, 3, 5, 2'b00, 2'b11, 1);
    step(0, 2'b11, 3, 5, 2'b00, 2'b10, 1);
    step(0, 2'b11, 3, 5, 2'b01, 2'b01, 1);
    step(0, 2'b11, 3, 5, 2'b00, 2'b01, 1);
    step(0, 2'b11, 3, 5, 2'b10, 2'b10, 1);

    // D: div=2, sync coincident with a wrap
    step(0, 2'b01, 2, 5, 2'b01, 2'b01, 0);
    step(0, 2'b01, 2, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 2, 5, 2'b01, 2'b01, 0);
    step(0, 2'b01, 2, 5, 2'b00, 2'b00, 0);
    step(1, 2'b01, 2, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 2, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 2, 5, 2'b01, 2'b01, 1);

    // E: div=0 and div=1, disable and re-enable
    step(0, 2'b01, 0, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 0, 5, 2'b01, 2'b01, 0);
    step(0, 2'b01, 0, 5, 2'b01, 2'b01, 0);
    step(0, 2'b01, 1, 5, 2'b01, 2'b01, 0);
    step(0, 2'b01, 1, 5, 2'b01, 2'b01, 0);
    step(1, 2'b01, 1, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 1, 5, 2'b01, 2'b01, 1);
    step(0, 2'b00, 1, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 1, 5, 2'b01, 2'b01, 0);

    // F: reset mid-period, then restart through the synchroniser
    step(1, 2'b01, 4, 5, 2'b00, 2'b00, 1);
    step(0, 2'b01, 4, 5, 2'b00, 2'b01, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk("async_reset_ce", step_idx, 8'(ce), 8'h0);
    chk("async_reset_div_clk", step_idx, 8'(div_clk), 8'h0);
    chk("async_reset_aligned", step_idx, 8'(aligned), 8'h0);
    @(negedge clk);
    @(negedge clk);
    chk("held_reset_ce", step_idx, 8'(ce), 8'h0);
    rstn = 1'b1;
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b01, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b00, 2'b00, 0);
    step(0, 2'b01, 4, 5, 2'b01, 2'b01, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
